// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, ALU control codes, arbiter FSM states and control-code legality check
package alu_pkg;
    localparam int DATA_W = 16;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
        return ctrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] cand;
    // Scan offsets from farthest to nearest so the requester closest above ptr wins last
    always_comb begin
        gnt = '0;
        idx = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                gnt = '0;
                gnt[cand] = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_ILLEGAL_OP_EN to add rsp_err and squash results of unknown control codes.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = alu_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic                      rsp_err,
`endif
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [3:0]                alu_ctrl,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_zero,
    output logic                      busy
);
    import alu_pkg::*;
    localparam int IDX_W = $clog2(NUM_REQ);
    state_t state, state_nx;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx, owner, ptr;
    logic [3:0] gnt_ctrl;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req(req_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gnt_idx)
    );
    assign gnt_ctrl = req_ctrl[gnt_idx*4 +: 4];
    // State register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // Grant when any request is valid, spend one cycle on the ALU, then wait for the owner to accept
    always_comb
        state_nx = (state == IDLE) ? (|req_valid ? EXEC : IDLE) :
                   (state == EXEC) ? RESP :
                   (rsp_ready[owner] ? IDLE : RESP);
    // Handshake outputs decoded from state; the response belongs to the registered owner
    always_comb begin
        req_ready = (state == IDLE) ? gnt : '0;
        rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
        busy = state != IDLE;
    end
    // Operand registers load at grant; response registers load from the ALU during EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            owner <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_ctrl <= ALU_AND;
            rsp_result <= '0;
            rsp_zero <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            rsp_err <= 1'b0;
`endif
        end else begin
            if (state == IDLE && |req_valid) begin
                alu_a <= req_a[gnt_idx*DATA_W +: DATA_W];
                alu_b <= req_b[gnt_idx*DATA_W +: DATA_W];
                alu_ctrl <= gnt_ctrl;
                owner <= gnt_idx;
                ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_err <= !is_legal_ctrl(gnt_ctrl);
`endif
            end
            if (state == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_result <= rsp_err ? '0 : alu_out;
                rsp_zero <= !rsp_err && alu_zero;
`else
                rsp_result <= alu_out;
                rsp_zero <= alu_zero;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, multi-cycle corner sequences and a randomized scoreboard for alu_arbiter
module tb_alu_arbiter;
    localparam int N = 2;
    localparam int W = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] rsp_ready = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*4-1:0] req_ctrl = '0;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_out;
    logic rsp_zero, alu_zero, busy;
    logic [3:0] alu_ctrl;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic rsp_err;
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    int checks = 0;
    int failures = 0;
    typedef struct {
        int r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] c;
        logic [W-1:0] res;
        logic z;
        logic err;
    } vec_t;
    logic [3:0] codes [7] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD};

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .rsp_err(rsp_err),
`endif
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_out(alu_out),
        .alu_zero(alu_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return {15'b0, $signed(a) < $signed(b)};
            4'hC: return ~(a | b);
            4'hD: return ~(a & b);
            default: return '0;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] c);
        return c == 4'h0 || c == 4'h1 || c == 4'h2 || c == 4'h6 || c == 4'h7 || c == 4'hC || c == 4'hD;
    endfunction

    // Behavioural ALU standing in for the shared instance
    always_comb begin
        alu_out = alu_fn(alu_a, alu_b, alu_ctrl);
        alu_zero = alu_out == '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain;
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int n;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        req_a[v.r*W +: W] = v.a;
        req_b[v.r*W +: W] = v.b;
        req_ctrl[v.r*4 +: 4] = v.c;
        rsp_ready = '1;
        n = 0;
        @(negedge clk);
        while (req_ready[v.r] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_grant"}, 32'(req_ready), 32'(1) << v.r);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk({nm, "_n1_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rsp_valid), 32'(1) << v.r);
        chk({nm, "_result"}, 32'(rsp_result), 32'(v.res));
        chk({nm, "_zero"}, 32'(rsp_zero), 32'(v.z));
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk({nm, "_err"}, 32'(rsp_err), 32'(v.err));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int gcyc [$];
        int gid [$];
        int g, own, age, ptr_m;
        bit pend, ill;
        logic [W-1:0] e_res, ea, eb;
        logic [3:0] ec;
        logic e_z;
        tbl[0] = '{0, 16'h0005, 16'h0003, 4'h2, 16'h0008, 1'b0, 1'b0};
        tbl[1] = '{1, 16'h1234, 16'h1234, 4'h6, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{0, 16'hFF00, 16'h0F0F, 4'h0, 16'h0F00, 1'b0, 1'b0};
        tbl[3] = '{1, 16'h00F0, 16'h0F00, 4'h1, 16'h0FF0, 1'b0, 1'b0};
        tbl[4] = '{0, 16'hFFFF, 16'h0001, 4'h7, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{1, 16'h0001, 16'hFFFF, 4'h7, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{0, 16'h0F0F, 16'h00F0, 4'hC, 16'hF000, 1'b0, 1'b0};
        tbl[7] = '{1, 16'hFFFF, 16'hFFFF, 4'hD, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{0, 16'hFFFF, 16'h0001, 4'h3, 16'h0000, !ILL_EN, ILL_EN};
        tbl[9] = '{1, 16'hFF00, 16'h0F0F, 4'h0, 16'h0F00, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));
        drain();
        // Contention: both requesters valid continuously
        pulse_reset();
        req_a[0 +: W] = 16'h0011;
        req_b[0 +: W] = 16'h0022;
        req_ctrl[3:0] = 4'h2;
        req_a[W +: W] = 16'h0100;
        req_b[W +: W] = 16'h0001;
        req_ctrl[7:4] = 4'h6;
        req_valid = '1;
        rsp_ready = '1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gcyc.push_back(c);
                gid.push_back(req_ready == 2'b10 ? 1 : 0);
                chk("cont_onehot", 32'($countones(req_ready)), 32'd1);
            end
        end
        chk("cont_grants", 32'(gid.size()), 32'd5);
        for (int k = 0; k < gid.size() && k < 5; k++) begin
            chk($sformatf("cont_order%0d", k), 32'(gid[k]), 32'(k % 2));
            chk($sformatf("cont_cycle%0d", k), 32'(gcyc[k]), 32'(3 * k));
        end
        drain();
        // Response backpressure with the other requester waiting
        pulse_reset();
        req_valid = 2'b01;
        req_a[0 +: W] = 16'h0102;
        req_b[0 +: W] = 16'h0304;
        req_ctrl[3:0] = 4'h2;
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        chk("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", 32'(rsp_result), 32'h0406);
            chk("bp_alu_a", 32'(alu_a), 32'h0102);
            chk("bp_alu_b", 32'(alu_b), 32'h0304);
            chk("bp_alu_ctrl", 32'(alu_ctrl), 32'h2);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_accept_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'd2);
        drain();
        // Reset during EXEC discards the operation
        req_valid = 2'b01;
        req_a[0 +: W] = 16'h7777;
        req_b[0 +: W] = 16'h0001;
        req_ctrl[3:0] = 4'h2;
        @(negedge clk);
        chk("rmo_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmo_req_ready", 32'(req_ready), 32'd0);
        chk("rmo_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rmo_rsp_result", 32'(rsp_result), 32'd0);
        chk("rmo_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rmo_alu_a", 32'(alu_a), 32'd0);
        chk("rmo_alu_b", 32'(alu_b), 32'd0);
        chk("rmo_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rmo_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rmo_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        chk("rmo_ptr_zero", 32'(req_ready), 32'd1);
        drain();
        // Randomized traffic against a transaction-level scoreboard
        pulse_reset();
        ptr_m = 0;
        pend = 1'b0;
        own = 0;
        age = 0;
        e_res = '0;
        e_z = 1'b0;
        ill = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = ($urandom_range(5) == 0) ? req_a[i*W +: W] : W'($urandom);
                req_ctrl[i*4 +: 4] = ($urandom_range(7) == 0) ? 4'($urandom) : codes[$urandom_range(6)];
            end
            rsp_ready = N'($urandom);
            @(negedge clk);
            if (!pend) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
                chk("rnd_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1) << g);
                chk("rnd_idle_valid", 32'(rsp_valid), 32'd0);
                chk("rnd_idle_busy", 32'(busy), 32'd0);
                if (g >= 0) begin
                    ea = req_a[g*W +: W];
                    eb = req_b[g*W +: W];
                    ec = req_ctrl[g*4 +: 4];
                    ill = ILL_EN && !legal(ec);
                    e_res = ill ? '0 : alu_fn(ea, eb, ec);
                    e_z = ill ? 1'b0 : (alu_fn(ea, eb, ec) == '0);
                    pend = 1'b1;
                    own = g;
                    age = 0;
                    ptr_m = (g + 1) % N;
                end
            end else begin
                age++;
                chk("rnd_busy_ready", 32'(req_ready), 32'd0);
                chk("rnd_busy", 32'(busy), 32'd1);
                if (age == 1) chk("rnd_exec_valid", 32'(rsp_valid), 32'd0);
                else begin
                    chk("rnd_valid", 32'(rsp_valid), 32'(1) << own);
                    chk("rnd_result", 32'(rsp_result), 32'(e_res));
                    chk("rnd_zero", 32'(rsp_zero), 32'(e_z));
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    chk("rnd_err", 32'(rsp_err), 32'(ill));
`endif
                    if (rsp_ready[own]) pend = 1'b0;
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
